// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The WB stage has priority. Multi-cycle results
// are queued in a small FIFO and drain when WB is idle. A starvation guard forces a
// one-cycle pipeline stall so the FIFO head can drain. Hazard flags tell decode
// which registers still have queued writes.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_Write_register,
  input  logic [DATA_W-1:0] wb_Write_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [4:0]        md_reg,
  input  logic [DATA_W-1:0] md_data,
  input  logic [4:0]        rd_reg1,
  input  logic [4:0]        rd_reg2,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              stall_pipe,
  output logic              RegWrite,
  output logic [4:0]        Write_register,
  output logic [DATA_W-1:0] Write_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    AGE_LAST = 4'(STARVE_LIMIT - 1);

  logic [4:0]        fifo_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [3:0]        age;
  logic [3:0]        age_nxt;
  logic              stall_nxt;
  logic              full;
  logic              empty;
  logic              wb_act;
  logic              push;
  logic              pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wb_act   = wb_RegWrite && (wb_Write_register != 5'd0);
  // md_ready reads the registered count, so a pop from a full FIFO frees a slot
  // only in the following cycle. During reset the FIFO refuses results.
  assign md_ready = reset && !full;
  // A result for register 0 completes the handshake but is dropped.
  assign push     = md_valid && md_ready && (md_reg != 5'd0);
  // The head drains on a forced stall or in any cycle where WB is idle.
  assign pop      = reset && !empty && (stall_pipe || !wb_act);

  // Write-port mux: a forced stall drains the head, then WB, then the FIFO.
  always_comb begin
    RegWrite       = 1'b0;
    Write_register = 5'd0;
    Write_data     = '0;
    if (reset) begin
      if (pop) begin
        RegWrite       = 1'b1;
        Write_register = fifo_reg[rd_ptr];
        Write_data     = fifo_data[rd_ptr];
      end else if (wb_act) begin
        RegWrite       = 1'b1;
        Write_register = wb_Write_register;
        Write_data     = wb_Write_data;
      end
    end
  end

  // Hazard lookup over every occupied slot. The slot being popped is still counted.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (rd_reg1 != 5'd0 && fifo_reg[rd_ptr + PW'(i)] == rd_reg1) pend_hit1 = 1'b1;
        if (rd_reg2 != 5'd0 && fifo_reg[rd_ptr + PW'(i)] == rd_reg2) pend_hit2 = 1'b1;
      end
    end
  end

  // Starvation guard: count the cycles the head loses to WB.
  // A stall is forced once the limit is reached.
  always_comb begin
    age_nxt   = age;
    stall_nxt = 1'b0;
    if (empty || pop) begin
      age_nxt = 4'd0;
    end else if (!stall_pipe && wb_act) begin
      if (age == AGE_LAST) begin
        stall_nxt = 1'b1;
      end else begin
        age_nxt = age + 4'd1;
      end
    end
  end

  // Control state: pointers, occupancy, age and the registered stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      age        <= 4'd0;
      stall_pipe <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      age        <= age_nxt;
      stall_pipe <= stall_nxt;
    end
  end

  // FIFO storage holds data only. Validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= md_reg;
      fifo_data[wr_ptr] <= md_data;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change 1 ns after the rising edge. Outputs are sampled 1 ns later.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_RegWrite;
  logic [4:0]  wb_Write_register;
  logic [31:0] wb_Write_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        stall_pipe;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_RegWrite(wb_RegWrite), .wb_Write_register(wb_Write_register),
    .wb_Write_data(wb_Write_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2), .stall_pipe(stall_pipe),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_RegWrite = en; wb_Write_register = r; wb_Write_data = d;
  endtask

  task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v; md_reg = r; md_data = d;
  endtask

  task automatic rf(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_we"}, 32'(RegWrite), 32'(we));
    chk({tag, "_reg"}, 32'(Write_register), 32'(r));
    chk({tag, "_data"}, Write_data, d);
  endtask

  initial begin
    reset = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    md(1'b0, 5'd0, 32'd0);
    rd_reg1 = 5'd0;
    rd_reg2 = 5'd0;
    #3;
    // Values held during reset.
    rf("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_ready", 32'(md_ready), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    chk("rst_hit1", 32'(pend_hit1), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(md_ready), 32'd1);

    // With WB idle, the queued write appears one cycle after acceptance.
    tick();
    md(1'b1, 5'd5, 32'hDEADBEEF);
    rd_reg1 = 5'd5;
    #1;
    chk("idle_hit_pre", 32'(pend_hit1), 32'd0);
    rf("idle_pre", 1'b0, 5'd0, 32'd0);
    tick();
    md(1'b0, 5'd0, 32'd0);
    #1;
    rf("idle_t1", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("idle_hit_t1", 32'(pend_hit1), 32'd1);
    tick();
    #1;
    chk("idle_hit_t2", 32'(pend_hit1), 32'd0);
    rf("idle_t2", 1'b0, 5'd0, 32'd0);

    // WB has priority over the FIFO head.
    md(1'b1, 5'd7, 32'h22);
    wb(1'b1, 5'd3, 32'h11);
    rd_reg1 = 5'd7;
    #1;
    rf("pri_c0", 1'b1, 5'd3, 32'h11);
    tick();
    md(1'b0, 5'd0, 32'd0);
    #1;
    rf("pri_c1", 1'b1, 5'd3, 32'h11);
    chk("pri_hit", 32'(pend_hit1), 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    rf("pri_c2", 1'b1, 5'd7, 32'h22);
    tick();
    #1;
    rf("pri_c3", 1'b0, 5'd0, 32'd0);
    rd_reg1 = 5'd0;

    // A full FIFO refuses a third result until a pop has been registered.
    wb(1'b1, 5'd9, 32'h99);
    md(1'b1, 5'd10, 32'hA0);
    rd_reg2 = 5'd12;
    #1;
    chk("full_rdy0", 32'(md_ready), 32'd1);
    tick();
    md(1'b1, 5'd11, 32'hB0);
    #1;
    chk("full_rdy1", 32'(md_ready), 32'd1);
    tick();
    md(1'b1, 5'd12, 32'hC0);
    #1;
    chk("full_rdy2", 32'(md_ready), 32'd0);
    chk("full_hit12", 32'(pend_hit2), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("full_rdy3", 32'(md_ready), 32'd0);
    rf("full_pop0", 1'b1, 5'd10, 32'hA0);
    tick();
    #1;
    chk("full_rdy4", 32'(md_ready), 32'd1);
    rf("full_pop1", 1'b1, 5'd11, 32'hB0);
    tick();
    md(1'b0, 5'd0, 32'd0);
    #1;
    rf("full_pop2", 1'b1, 5'd12, 32'hC0);
    chk("full_hit12b", 32'(pend_hit2), 32'd1);
    tick();
    rd_reg2 = 5'd0;
    #1;
    rf("full_empty", 1'b0, 5'd0, 32'd0);

    // Starvation: WB is active every cycle while one entry waits.
    wb(1'b1, 5'd1, 32'h100);
    md(1'b1, 5'd20, 32'hABCD);
    #1;
    rf("stv_c0", 1'b1, 5'd1, 32'h100);
    tick();
    md(1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("stv_stall_c%0d", c), 32'(stall_pipe), 32'd0);
      rf($sformatf("stv_c%0d", c), 1'b1, 5'd1, 32'h100);
      tick();
    end
    #1;
    chk("stv_stall_c5", 32'(stall_pipe), 32'd1);
    rf("stv_c5", 1'b1, 5'd20, 32'hABCD);
    tick();
    #1;
    chk("stv_stall_c6", 32'(stall_pipe), 32'd0);
    rf("stv_c6", 1'b1, 5'd1, 32'h100);
    tick();
    wb(1'b0, 5'd0, 32'd0);

    // Register 0: the result is dropped, and a WB write to r0 counts as idle.
    md(1'b1, 5'd0, 32'h55);
    #1;
    tick();
    md(1'b0, 5'd0, 32'd0);
    #1;
    rf("r0_md", 1'b0, 5'd0, 32'd0);
    chk("r0_ready", 32'(md_ready), 32'd1);
    md(1'b1, 5'd6, 32'h66);
    wb(1'b1, 5'd4, 32'h44);
    #1;
    tick();
    md(1'b0, 5'd0, 32'd0);
    wb(1'b1, 5'd0, 32'h77);
    #1;
    rf("r0_wb", 1'b1, 5'd6, 32'h66);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    #1;
    rf("r0_after", 1'b0, 5'd0, 32'd0);

    // Asynchronous reset in the middle of operation, with two entries queued.
    wb(1'b1, 5'd2, 32'h2);
    md(1'b1, 5'd8, 32'h8);
    rd_reg1 = 5'd8;
    #1;
    tick();
    md(1'b1, 5'd9, 32'h9);
    #1;
    tick();
    md(1'b0, 5'd0, 32'd0);
    #1;
    chk("mid_hit_pre", 32'(pend_hit1), 32'd1);
    chk("mid_rdy_pre", 32'(md_ready), 32'd0);
    reset = 1'b0;
    #1;
    rf("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_hit_rst", 32'(pend_hit1), 32'd0);
    chk("mid_rdy_rst", 32'(md_ready), 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rdy_rel", 32'(md_ready), 32'd1);
    chk("mid_hit_rel", 32'(pend_hit1), 32'd0);
    rf("mid_rel", 1'b0, 5'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
